// File: rtl/axi_slave_default.sv
// Default AXI slave for unmapped interconnect ports: accepts every burst, answers with fixed
// responses and a constant read pattern, and keeps a saturating completion count plus last address.

module axi_slave_default #(
    parameter int          ID_WIDTH   = 4,
    parameter logic [1:0]  WR_RESP    = 2'b11,
    parameter logic [1:0]  RD_RESP    = 2'b11,
    parameter logic [31:0] RD_PATTERN = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                SLAVE_CLK,
    output logic                SLAVE_RSTN,

    input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
    input  logic [31:0]         SLAVE_WR_ADDR,
    input  logic [7:0]          SLAVE_WR_ADDR_LEN,
    input  logic [1:0]          SLAVE_WR_ADDR_BURST,
    input  logic                SLAVE_WR_ADDR_VALID,
    output logic                SLAVE_WR_ADDR_READY,

    input  logic [31:0]         SLAVE_WR_DATA,
    input  logic [3:0]          SLAVE_WR_STRB,
    input  logic                SLAVE_WR_DATA_LAST,
    input  logic                SLAVE_WR_DATA_VALID,
    output logic                SLAVE_WR_DATA_READY,

    output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
    output logic [1:0]          SLAVE_WR_BACK_RESP,
    output logic                SLAVE_WR_BACK_VALID,
    input  logic                SLAVE_WR_BACK_READY,

    input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
    input  logic [31:0]         SLAVE_RD_ADDR,
    input  logic [7:0]          SLAVE_RD_ADDR_LEN,
    input  logic [1:0]          SLAVE_RD_ADDR_BURST,
    input  logic                SLAVE_RD_ADDR_VALID,
    output logic                SLAVE_RD_ADDR_READY,

    output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
    output logic [31:0]         SLAVE_RD_DATA,
    output logic [1:0]          SLAVE_RD_DATA_RESP,
    output logic                SLAVE_RD_DATA_LAST,
    output logic                SLAVE_RD_DATA_VALID,
    input  logic                SLAVE_RD_DATA_READY,

    output logic [15:0]         access_cnt,
    output logic [31:0]         last_addr,

    input  logic                i_dbg_cnt_load,
    input  logic [15:0]         i_dbg_cnt_value,
    output logic [1:0]          o_dbg_wr_state,
    output logic                o_dbg_rd_state
);

    // VALID/READY: a beat transfers on every rising edge where both are high; the source keeps its
    // payload stable while VALID && !READY. Every READY/VALID here is a decode of registered state.

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    wr_state_t r_wr_state;
    wr_state_t w_wr_state_nxt;
    rd_state_t r_rd_state;
    rd_state_t w_rd_state_nxt;

    // Low during reset and for the first cycle after release, so the address channels stay closed
    logic                r_awake;

    logic [ID_WIDTH-1:0] r_wr_id;
    logic [7:0]          r_wr_len;
    logic [7:0]          r_wbeat;
    logic [1:0]          r_wr_resp;

    logic [ID_WIDTH-1:0] r_rd_id;
    logic [7:0]          r_rd_len;
    logic [7:0]          r_rbeat;

    logic [15:0]         r_access_cnt;
    logic [31:0]         r_last_addr;

    logic                w_aw_ready;
    logic                w_w_ready;
    logic                w_b_valid;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;

    logic                w_ar_ready;
    logic                w_r_valid;
    logic                w_r_last;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_r_done;

    logic [1:0]          w_cnt_inc;
    logic [16:0]         w_cnt_sum;
    logic                w_unused_inputs;

    assign SLAVE_CLK  = clk;
    assign SLAVE_RSTN = rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_awake <= 1'b0;
        end else begin
            r_awake <= 1'b1;
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_ready     = 1'b0;
        w_w_ready      = 1'b0;
        w_b_valid      = 1'b0;
        case (r_wr_state)
            W_IDLE: w_aw_ready = r_awake;
            W_DATA: w_w_ready  = 1'b1;
            W_RESP: w_b_valid  = 1'b1;
            default: ;
        endcase
        w_aw_hs = SLAVE_WR_ADDR_VALID && w_aw_ready;
        w_w_hs  = SLAVE_WR_DATA_VALID && w_w_ready;
        w_b_hs  = w_b_valid && SLAVE_WR_BACK_READY;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && SLAVE_WR_DATA_LAST) w_wr_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Only LAST closes a burst; a beat count that disagrees with LEN turns the response into SLVERR
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_id   <= '0;
            r_wr_len  <= 8'd0;
            r_wbeat   <= 8'd0;
            r_wr_resp <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_wr_id  <= SLAVE_WR_ADDR_ID;
                r_wr_len <= SLAVE_WR_ADDR_LEN;
                r_wbeat  <= 8'd0;
            end
            if (w_w_hs) begin
                r_wbeat <= r_wbeat + 8'd1;
                if (SLAVE_WR_DATA_LAST) begin
                    r_wr_resp <= (r_wbeat == r_wr_len) ? WR_RESP : 2'b10;
                end
            end
        end
    end

    assign SLAVE_WR_ADDR_READY = w_aw_ready;
    assign SLAVE_WR_DATA_READY = w_w_ready;
    assign SLAVE_WR_BACK_VALID = w_b_valid;
    assign SLAVE_WR_BACK_ID    = w_b_valid ? r_wr_id : '0;
    assign SLAVE_WR_BACK_RESP  = w_b_valid ? r_wr_resp : 2'b00;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_ar_ready     = 1'b0;
        w_r_valid      = 1'b0;
        w_r_last       = 1'b0;
        case (r_rd_state)
            R_IDLE: w_ar_ready = r_awake;
            R_DATA: begin
                w_r_valid = 1'b1;
                w_r_last  = (r_rbeat == r_rd_len);
            end
            default: ;
        endcase
        w_ar_hs  = SLAVE_RD_ADDR_VALID && w_ar_ready;
        w_r_hs   = w_r_valid && SLAVE_RD_DATA_READY;
        w_r_done = w_r_hs && w_r_last;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
            R_DATA:  if (w_r_done) w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_id  <= '0;
            r_rd_len <= 8'd0;
            r_rbeat  <= 8'd0;
        end else begin
            if (w_ar_hs) begin
                r_rd_id  <= SLAVE_RD_ADDR_ID;
                r_rd_len <= SLAVE_RD_ADDR_LEN;
                r_rbeat  <= 8'd0;
            end else if (w_r_hs) begin
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

    assign SLAVE_RD_ADDR_READY = w_ar_ready;
    assign SLAVE_RD_DATA_VALID = w_r_valid;
    assign SLAVE_RD_DATA_LAST  = w_r_last;
    assign SLAVE_RD_BACK_ID    = w_r_valid ? r_rd_id : '0;
    assign SLAVE_RD_DATA       = w_r_valid ? RD_PATTERN : 32'd0;
    assign SLAVE_RD_DATA_RESP  = w_r_valid ? RD_RESP : 2'b00;

    // ---------------- debug counters ----------------
    // A write response and a final read beat can land on the same edge, hence a 2-bit increment
    assign w_cnt_inc = {1'b0, w_b_hs} + {1'b0, w_r_done};
    assign w_cnt_sum = {1'b0, r_access_cnt} + {15'd0, w_cnt_inc};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_access_cnt <= 16'd0;
        end else if (i_dbg_cnt_load) begin
            r_access_cnt <= i_dbg_cnt_value;
        end else if (w_cnt_sum[16]) begin
            r_access_cnt <= 16'hFFFF;
        end else begin
            r_access_cnt <= w_cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_addr <= 32'd0;
        end else if (w_ar_hs) begin
            r_last_addr <= SLAVE_RD_ADDR;
        end else if (w_aw_hs) begin
            r_last_addr <= SLAVE_WR_ADDR;
        end
    end

    assign access_cnt     = r_access_cnt;
    assign last_addr      = r_last_addr;
    assign o_dbg_wr_state = r_wr_state;
    assign o_dbg_rd_state = r_rd_state;

    assign w_unused_inputs = ^{SLAVE_WR_ADDR_BURST, SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_RD_ADDR_BURST};

endmodule

// File: tb/tb_axi_slave_default.sv
// Bench for axi_slave_default: directed bursts with expected B/R responses queued at issue time and
// checked by an independent monitor whenever the slave presents a response.

module tb_axi_slave_default;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        slave_clk, slave_rstn;
  logic [3:0]  aw_id;  logic [31:0] aw_addr; logic [7:0] aw_len; logic [1:0] aw_burst;
  logic        aw_valid, aw_ready;
  logic [31:0] w_data; logic [3:0] w_strb; logic w_last, w_valid, w_ready;
  logic [3:0]  b_id;   logic [1:0] b_resp;  logic b_valid, b_ready;
  logic [3:0]  ar_id;  logic [31:0] ar_addr; logic [7:0] ar_len; logic [1:0] ar_burst;
  logic        ar_valid, ar_ready;
  logic [3:0]  r_id;   logic [31:0] r_data; logic [1:0] r_resp; logic r_last, r_valid, r_ready;
  logic [15:0] access_cnt; logic [31:0] last_addr;
  logic        cnt_load; logic [15:0] cnt_value;
  logic [1:0]  dbg_wr_state; logic dbg_rd_state;

  axi_slave_default dut (
    .clk(clk), .rstn(rstn), .SLAVE_CLK(slave_clk), .SLAVE_RSTN(slave_rstn),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
    .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp), .SLAVE_WR_BACK_VALID(b_valid),
    .SLAVE_WR_BACK_READY(b_ready),
    .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
    .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
    .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
    .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready),
    .access_cnt(access_cnt), .last_addr(last_addr),
    .i_dbg_cnt_load(cnt_load), .i_dbg_cnt_value(cnt_value),
    .o_dbg_wr_state(dbg_wr_state), .o_dbg_rd_state(dbg_rd_state)
  );

  // ---------------- scoreboard state ----------------
  logic [5:0]  exp_b_q[$];   // {id, resp}
  logic [38:0] exp_r_q[$];   // {id, data, resp, last}
  logic [15:0] exp_cnt;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no handshake within the cycle budget, required one", name);
  endtask

  // ---------------- driver tasks (called and returning at posedge+1) ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = 2'b01; aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    if (!aw_ready) fail_timeout("aw_handshake");
    sync();
    aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = 2'b01; ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!ar_ready) fail_timeout("ar_handshake");
    sync();
    ar_valid = 1'b0;
  endtask

  // LAST rides on the final beat sent
  task automatic w_send(input int nbeats);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      w_valid = 1'b1; w_data = 32'hA500_0000 + i; w_strb = 4'hF; w_last = (i == nbeats - 1);
      n = 0;
      @(negedge clk);
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      if (!w_ready) begin
        fail_timeout("w_handshake");
        sync();
        break;
      end
      sync();
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] id, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++)
      exp_r_q.push_back({id, 32'hDEAD_BEEF, 2'b11, (i == int'(len))});
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input int nbeats, input logic [1:0] resp);
    exp_b_q.push_back({id, resp});
    aw_send(id, addr, len);
    w_send(nbeats);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 1000) begin sync(); n++; end
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      fail_timeout(name);
      exp_b_q.delete();
      exp_r_q.delete();
    end
    sync();
  endtask

  // AW(len 0, one beat) and AR(len 1) accepted together; B and final R land on the same edge
  task automatic concurrent_pair(input logic [31:0] wa, input logic [31:0] ra);
    exp_b_q.push_back({4'd1, 2'b11});
    push_read(4'd2, 8'd1);
    fork
      aw_send(4'd1, wa, 8'd0);
      w_send(1);
      ar_send(4'd2, ra, 8'd1);
    join
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (b_valid) begin
      if (exp_b_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected: got id=0x%0h resp=%0b, required no response", b_id, b_resp);
      end else begin
        check("b_response", {b_id, b_resp}, exp_b_q[0]);
        if (b_ready) void'(exp_b_q.pop_front());
      end
    end
    if (r_valid) begin
      if (exp_r_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL r_unexpected: got id=0x%0h data=0x%0h last=%0b, required no beat", r_id, r_data, r_last);
      end else begin
        check("r_beat", {r_id, r_data, r_resp, r_last}, exp_r_q[0]);
        if (r_ready) void'(exp_r_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  logic [3:0]  wv_id[4]    = '{4'd1, 4'd2, 4'hF, 4'd7};
  logic [31:0] wv_addr[4]  = '{32'h50, 32'h60, 32'h70, 32'h80};
  logic [7:0]  wv_len[4]   = '{8'd3, 8'd1, 8'd0, 8'd255};
  int          wv_beats[4] = '{2, 4, 1, 256};
  logic [1:0]  wv_resp[4]  = '{2'b10, 2'b10, 2'b11, 2'b11};
  logic [15:0] sat_exp[3]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF};

  initial begin
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 1'b0; r_ready = 1'b1;
    cnt_load = 1'b0; cnt_value = '0; exp_cnt = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_ready", aw_ready, 0);
    check("rst_ar_ready", ar_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_access_cnt", access_cnt, 0);
    check("rst_last_addr", last_addr, 0);
    check("rst_slave_rstn", slave_rstn, 0);
    check("rst_wr_state", dbg_wr_state, 0);
    rstn = 1'b1;
    check("release_ar_ready", ar_ready, 0);
    sync();
    check("awake_aw_ready", aw_ready, 1);
    check("awake_ar_ready", ar_ready, 1);
    check("awake_slave_rstn", slave_rstn, 1);

    // W presented with no AW outstanding must be held off
    w_valid = 1'b1; w_last = 1'b1; w_data = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      check("w_ready_idle", w_ready, 0);
    end
    sync();
    w_valid = 1'b0; w_last = 1'b0;

    // Test 1: well-formed write
    exp_b_q.push_back({4'd3, 2'b11});
    aw_send(4'd3, 32'h40, 8'd3);
    check("t1_w_ready_after_aw", w_ready, 1);
    w_send(4);
    check("t1_bvalid_after_last", b_valid, 1);
    exp_cnt = 16'd1;
    wait_drain("t1_drain");
    check("t1_access_cnt", access_cnt, exp_cnt);
    check("t1_last_addr", last_addr, 32'h40);

    // Test 2: early/late LAST, single beat, 256 beats; B stalled on the second vector
    for (int i = 0; i < 4; i++) begin
      if (i == 1) b_ready = 1'b0;
      write_burst(wv_id[i], wv_addr[i], wv_len[i], wv_beats[i], wv_resp[i]);
      if (i == 1) begin
        repeat (3) sync();
        b_ready = 1'b1;
      end
      exp_cnt = exp_cnt + 16'd1;
      wait_drain("t2_drain");
      check("t2_access_cnt", access_cnt, exp_cnt);
      check("t2_last_addr", last_addr, wv_addr[i]);
    end

    // Test 3: 8-beat read under toggling RREADY
    push_read(4'd5, 8'd7);
    r_ready = 1'b0;
    fork
      ar_send(4'd5, 32'h300, 8'd7);
      for (int i = 0; i < 100 && exp_r_q.size() != 0; i++) begin
        sync();
        r_ready = ~r_ready;
      end
    join
    r_ready = 1'b1;
    exp_cnt = exp_cnt + 16'd1;
    wait_drain("t3_drain");
    check("t3_r_valid_done", r_valid, 0);
    check("t3_access_cnt", access_cnt, exp_cnt);
    check("t3_last_addr", last_addr, 32'h300);

    // Read length boundaries
    push_read(4'd9, 8'd0);
    ar_send(4'd9, 32'h310, 8'd0);
    wait_drain("len0_drain");
    push_read(4'hA, 8'd255);
    ar_send(4'hA, 32'h320, 8'd255);
    wait_drain("len255_drain");
    exp_cnt = exp_cnt + 16'd2;
    check("len_access_cnt", access_cnt, exp_cnt);

    // Test 4: concurrent write and read completing together
    concurrent_pair(32'h100, 32'h200);
    check("t4_cnt_before_done", access_cnt, exp_cnt);
    exp_cnt = exp_cnt + 16'd2;
    wait_drain("t4_drain");
    check("t4_access_cnt", access_cnt, exp_cnt);
    check("t4_last_addr", last_addr, 32'h200);

    // Test 5: reset during beat 3 of an 8-beat read
    push_read(4'd6, 8'd7);
    ar_send(4'd6, 32'h400, 8'd7);
    sync();
    sync();
    check("t5_r_valid_beat3", r_valid, 1);
    #2 rstn = 1'b0;
    #1;
    exp_r_q.delete();
    exp_cnt = 16'd0;
    check("t5_r_valid_in_reset", r_valid, 0);
    check("t5_r_last_in_reset", r_last, 0);
    check("t5_ar_ready_in_reset", ar_ready, 0);
    check("t5_access_cnt_in_reset", access_cnt, 0);
    check("t5_last_addr_in_reset", last_addr, 0);
    sync();
    rstn = 1'b1;
    check("t5_ar_ready_at_release", ar_ready, 0);
    sync();
    check("t5_ar_ready_after_release", ar_ready, 1);
    check("t5_access_cnt_after", access_cnt, 0);
    push_read(4'd3, 8'd0);
    ar_send(4'd3, 32'h410, 8'd0);
    exp_cnt = 16'd1;
    wait_drain("t5_drain");
    check("t5_access_cnt_recover", access_cnt, exp_cnt);

    // Test 6: saturation from 0xFFFE
    cnt_load = 1'b1; cnt_value = 16'hFFFE;
    sync();
    cnt_load = 1'b0;
    check("t6_preload", access_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      push_read(4'd4, 8'd0);
      ar_send(4'd4, 32'h500 + i, 8'd0);
      wait_drain("t6_drain");
      check("t6_saturate", access_cnt, sat_exp[i]);
    end
    cnt_load = 1'b1; cnt_value = 16'hFFFE;
    sync();
    cnt_load = 1'b0;
    concurrent_pair(32'h600, 32'h700);
    wait_drain("t6_pair_drain");
    check("t6_pair_saturate", access_cnt, 16'hFFFF);
    check("t6_pair_last_addr", last_addr, 32'h700);

    repeat (3) sync();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
